seg_scan_driver: RTL and testbench

Time-multiplexed 4-digit 7-segment driver, downstream of the timer core. Consumes BCD digit values (secs, ten_secs, mins, spare) plus decimal-point and blink controls, and produces registered SEG/DIGIT pins. Adds frame-synchronous input capture, anti-ghost blanking, leading-zero suppression and a blink gate for the SETTING/BEEPING indication.

---
 rtl/seg_scan_driver_pkg.sv | 36 +++
 rtl/seg_scan_driver_seg7.sv | 28 ++
 rtl/seg_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg_scan_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 4-digit segment scanner: segment bit positions,
// active-low glyphs for the decoder and the all-off pin patterns.
package seg_scan_driver_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs are bits [6:0] = g..a, active-low (0 lights the segment).
    localparam logic [6:0] GLYPH_0    = 7'b1000000;
    localparam logic [6:0] GLYPH_1    = 7'b1111001;
    localparam logic [6:0] GLYPH_2    = 7'b0100100;
    localparam logic [6:0] GLYPH_3    = 7'b0110000;
    localparam logic [6:0] GLYPH_4    = 7'b0011001;
    localparam logic [6:0] GLYPH_5    = 7'b0010010;
    localparam logic [6:0] GLYPH_6    = 7'b0000010;
    localparam logic [6:0] GLYPH_7    = 7'b1111000;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0010000;
    localparam logic [6:0] GLYPH_DASH = 7'b0111111;
    localparam logic [6:0] GLYPH_OFF  = 7'b1111111;

    localparam logic [3:0] DIGIT_OFF = 4'hF;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_DARK    = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/seg_scan_driver_seg7.sv
// Combinational BCD-to-7-segment decoder: 0-9 glyphs, 0xA as a dash,
// every other code blank.
module seg7_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_OFF;
        case (value)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            4'hA:    glyph = GLYPH_DASH;
            default: glyph = GLYPH_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with frame-synchronous input
// capture, anti-ghost blanking, leading-zero suppression and whole-display blink.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int CLK_HZ       = 12000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_HZ     = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [7:0] SEG,
    output logic [3:0] DIGIT,
    output logic       frame_tick
);

    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int SLOT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [SLOT_W-1:0]  slot_cnt;
    logic [1:0]         idx;
    logic               primed;
    logic [3:0][3:0]    snap_d;
    logic [3:0]         snap_dp;
    logic               snap_lz;
    logic [BLINK_W-1:0] blink_cnt;
    blink_phase_t       phase;

    logic       slot_wrap;
    logic       capture;
    logic       blank_digit;
    logic [6:0] glyph;
    logic [7:0] seg_next;
    logic [3:0] digit_next;

    assign slot_wrap = (slot_cnt == SLOT_W'(DIV - 1));
    // The first edge after reset takes a snapshot so the display never runs
    // a whole frame on the cleared registers.
    assign capture   = !primed || (slot_wrap && idx == 2'd3);

    seg7_decode u_decode (
        .value (snap_d[idx]),
        .glyph (glyph)
    );

    // A digit is a leading zero only if every digit to its left is zero too.
    always_comb begin
        blank_digit = 1'b0;
        case (idx)
            2'd3:    blank_digit = snap_lz && (snap_d[3] == 4'd0);
            2'd2:    blank_digit = snap_lz && (snap_d[3] == 4'd0) && (snap_d[2] == 4'd0);
            2'd1:    blank_digit = snap_lz && (snap_d[3] == 4'd0) && (snap_d[2] == 4'd0)
                                   && (snap_d[1] == 4'd0);
            default: blank_digit = 1'b0;
        endcase
    end

    always_comb begin
        seg_next   = SEG_OFF;
        digit_next = DIGIT_OFF;
        if (phase == PHASE_VISIBLE && slot_cnt >= SLOT_W'(BLANK_CYCLES)) begin
            digit_next      = ~(4'b0001 << idx);
            seg_next[SEG_DP] = ~snap_dp[idx];
            seg_next[6:0]   = blank_digit ? GLYPH_OFF : glyph;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            slot_cnt   <= '0;
            idx        <= 2'd0;
            primed     <= 1'b0;
            snap_d     <= '0;
            snap_dp    <= 4'd0;
            snap_lz    <= 1'b0;
            frame_tick <= 1'b0;
            SEG        <= SEG_OFF;
            DIGIT      <= DIGIT_OFF;
        end else begin
            primed     <= 1'b1;
            frame_tick <= capture;
            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (capture) begin
                snap_d  <= {d3, d2, d1, d0};
                snap_dp <= dp_mask;
                snap_lz <= blank_lz;
            end
            SEG   <= seg_next;
            DIGIT <= digit_next;
        end
    end

    // blink_en is live, not snapshotted, so the display can be lit again at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            blink_cnt <= '0;
            phase     <= PHASE_VISIBLE;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase     <= PHASE_VISIBLE;
        end else if (blink_cnt == BLINK_W'(HALF - 1)) begin
            blink_cnt <= '0;
            phase     <= (phase == PHASE_VISIBLE) ? PHASE_DARK : PHASE_VISIBLE;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-position model of the display checked
// every cycle, plus directed scenarios with hand-computed pin values.
module tb_seg_scan_driver;

    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int HALF  = 50;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d0, d1, d2, d3, dp_mask;
    logic       blank_lz, blink_en;
    logic [7:0] seg;
    logic [3:0] digit;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;

    // Model state: t = clock edges since reset release, run = consecutive
    // edges with blink_en high, m_* = expected snapshot.
    int         t = 0;
    int         run = 0;
    logic [3:0] m_d [4];
    logic [3:0] m_dp;
    logic       m_lz;
    logic [6:0] glyph_tab [16];
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_tick;
    int         p, cnt, ix;
    bit         lz;

    seg_scan_driver #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2),
        .BLINK_HZ     (10)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .SEG        (seg),
        .DIGIT      (digit),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0d: got %h, expected %h", name, t, act, exp);
        end
    endtask

    task automatic goto(input int n);
        int guard = 0;
        while (t < n && guard < 2000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        tests++;
        if (t < n) begin
            fails++;
            $display("FAIL goto: reached t=%0d, expected t=%0d", t, n);
        end
    endtask

    // Every-cycle model compare.
    always begin
        @(posedge clk);
        if (rst) begin
            t = 0;
            run = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
            m_dp   = 4'd0;
            m_lz   = 1'b0;
            e_seg  = 8'hFF;
            e_dig  = 4'hF;
            e_tick = 1'b0;
        end else begin
            t++;
            p   = t - 1;
            cnt = p % DIV;
            ix  = (p / DIV) % 4;
            e_seg = 8'hFF;
            e_dig = 4'hF;
            if (((run / HALF) % 2) == 0 && cnt >= BLANK) begin
                lz = m_lz && (ix > 0);
                for (int j = ix; j < 4; j++) if (m_d[j] != 4'd0) lz = 1'b0;
                e_dig[ix]  = 1'b0;
                e_seg[7]   = ~m_dp[ix];
                e_seg[6:0] = lz ? 7'h7F : glyph_tab[m_d[ix]];
            end
            e_tick = (t == 1) || (t % FRAME == 0);
            if (e_tick) begin
                m_d[0] = d0; m_d[1] = d1; m_d[2] = d2; m_d[3] = d3;
                m_dp = dp_mask;
                m_lz = blank_lz;
            end
            if (blink_en) run++;
            else run = 0;
        end
        #1;
        check("model_seg", seg, e_seg);
        check("model_digit", {4'h0, digit}, {4'h0, e_dig});
        check("model_tick", {7'h0, frame_tick}, {7'h0, e_tick});
    end

    initial begin
        glyph_tab[0]  = 7'h40; glyph_tab[1]  = 7'h79; glyph_tab[2]  = 7'h24;
        glyph_tab[3]  = 7'h30; glyph_tab[4]  = 7'h19; glyph_tab[5]  = 7'h12;
        glyph_tab[6]  = 7'h02; glyph_tab[7]  = 7'h78; glyph_tab[8]  = 7'h00;
        glyph_tab[9]  = 7'h10; glyph_tab[10] = 7'h3F;
        for (int i = 11; i < 16; i++) glyph_tab[i] = 7'h7F;

        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        dp_mask = 4'b0100; blank_lz = 1'b0; blink_en = 1'b0;

        // Reset state
        @(posedge clk); #2;
        check("rst_seg", seg, 8'hFF);
        check("rst_digit", {4'h0, digit}, 8'h0F);
        check("rst_tick", {7'h0, frame_tick}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Scan order, glyphs 1..4, dp on digit2 only
        goto(1);   check("first_tick", {7'h0, frame_tick}, 8'h01);
                   check("first_blank", {4'h0, digit}, 8'h0F);
        goto(3);   check("scan0_dig", {4'h0, digit}, 8'h0E); check("scan0_seg", seg, 8'hF9);
        goto(13);  check("scan1_dig", {4'h0, digit}, 8'h0D); check("scan1_seg", seg, 8'hA4);
        goto(23);  check("scan2_dig", {4'h0, digit}, 8'h0B); check("scan2_seg", seg, 8'h30);
        goto(33);  check("scan3_dig", {4'h0, digit}, 8'h07); check("scan3_seg", seg, 8'h99);

        // Frame sync: a change while digit0 is on screen waits for the next frame
        goto(45);  d0 = 4'd5;
        goto(84);  d0 = 4'd7;
        goto(88);  check("sync_old_seg", seg, 8'h92);
        goto(120); check("sync_tick", {7'h0, frame_tick}, 8'h01);
        goto(123); check("sync_new_seg", seg, 8'hF8);

        // Leading zeros 0,0,0,5
        goto(125); d0 = 4'd5; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; blank_lz = 1'b1;
        goto(163); check("lz0_seg", seg, 8'h92);
        goto(173); check("lz1_seg", seg, 8'hFF); check("lz1_dig", {4'h0, digit}, 8'h0D);
        goto(183); check("lz2_seg", seg, 8'h7F);
        goto(193); check("lz3_seg", seg, 8'hFF); check("lz3_dig", {4'h0, digit}, 8'h07);

        // Leading zeros 0,1,0,0
        goto(195); d0 = 4'd0; d2 = 4'd1;
        goto(203); check("lzb0_seg", seg, 8'hC0);
        goto(213); check("lzb1_seg", seg, 8'hC0);
        goto(223); check("lzb2_seg", seg, 8'h79);
        goto(233); check("lzb3_seg", seg, 8'hFF);

        // Glyph edges: dash and blank code
        goto(235); d0 = 4'hA; blank_lz = 1'b0;
        goto(243); check("dash_seg", seg, 8'hBF);
        goto(245); d0 = 4'hC;
        goto(283); check("blankcode_seg", seg, 8'hFF); check("blankcode_dig", {4'h0, digit}, 8'h0E);

        // Blink: 50 visible, 50 dark, drop during dark phase
        goto(290); blink_en = 1'b1;
        goto(335); check("blink_vis_dig", {4'h0, digit}, 8'h0D);
        goto(345); check("blink_dark_dig", {4'h0, digit}, 8'h0F); check("blink_dark_seg", seg, 8'hFF);
        goto(395); check("blink_vis2_dig", {4'h0, digit}, 8'h07);
        goto(453); blink_en = 1'b0;
        goto(454); check("blink_drop_dark", {4'h0, digit}, 8'h0F);
        goto(455); check("blink_drop_vis", {4'h0, digit}, 8'h0D);

        // Reset mid-frame: pins off at once, fresh snapshot after release
        goto(460);
        #1 rst = 1'b1;
        d0 = 4'd8; d2 = 4'd0;
        #1;
        check("midrst_seg", seg, 8'hFF);
        check("midrst_digit", {4'h0, digit}, 8'h0F);
        check("midrst_tick", {7'h0, frame_tick}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        goto(1);   check("rerst_tick", {7'h0, frame_tick}, 8'h01);
        goto(3);   check("rerst_seg", seg, 8'h80); check("rerst_dig", {4'h0, digit}, 8'h0E);
        goto(45);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
